// File: rtl/mem_stage_if.sv
// Data-memory port between the memory-access stage (master) and the data memory (slave).
// The request side is registered in the stage; ack/rdata come back from memory.
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: branch resolution, load/store over a req/ack data port
// with timeout, upstream stall generation and the MEM/WB pipeline register.
module mem_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        reg_write_i,
  input  logic        mem_to_reg_i,
  input  logic        zero_i,
  input  logic [31:0] add_result_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rdata2_i,
  input  logic [4:0]  write_reg_i,
  mem_stage_if.master dmem,
  output logic        stall_o,
  output logic        pc_src_o,
  output logic [31:0] branch_target_o,
  output logic        reg_write_wb_o,
  output logic        mem_to_reg_wb_o,
  output logic [31:0] read_data_wb_o,
  output logic [31:0] alu_result_wb_o,
  output logic [4:0]  write_reg_wb_o,
  output logic        align_err_o,
  output logic        bus_err_o
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  write_reg;
  } wb_t;

  // Last counter value before the access is abandoned; the counter stops here.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  wb_t         wb_q, wb_d;
  logic        align_err_q, align_err_d;
  logic        bus_err_q, bus_err_d;

  logic        mem_op;
  logic        misaligned;
  logic        stall;
  wb_t         wb_in;

  always_comb begin
    mem_op     = mem_read_i | mem_write_i;
    misaligned = mem_op & (alu_result_i[1:0] != 2'b00);
    wb_in      = '{reg_write:  reg_write_i,
                   mem_to_reg: mem_to_reg_i,
                   read_data:  32'h0,
                   alu_result: alu_result_i,
                   write_reg:  write_reg_i};
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wb_d        = wb_q;
    align_err_d = 1'b0;
    bus_err_d   = 1'b0;
    stall       = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_op && !misaligned) begin
          stall           = 1'b1;
          state_d         = ACCESS;
          req_d           = 1'b1;
          we_d            = mem_write_i;
          addr_d          = alu_result_i;
          wdata_d         = rdata2_i;
          cnt_d           = 8'd0;
          wb_d.reg_write  = 1'b0;
          wb_d.mem_to_reg = 1'b0;
        end else begin
          // Non-memory instructions pass straight through; a misaligned op is
          // retired with its register write suppressed.
          wb_d           = wb_in;
          wb_d.reg_write = reg_write_i & ~misaligned;
          align_err_d    = misaligned;
        end
      end

      ACCESS: begin
        if (dmem.ack) begin
          state_d        = IDLE;
          req_d          = 1'b0;
          wb_d           = wb_in;
          wb_d.read_data = we_q ? 32'h0 : dmem.rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d        = IDLE;
          req_d          = 1'b0;
          bus_err_d      = 1'b1;
          wb_d           = wb_in;
          wb_d.reg_write = 1'b0;
        end else begin
          stall           = 1'b1;
          cnt_d           = cnt_q + 8'd1;
          wb_d.reg_write  = 1'b0;
          wb_d.mem_to_reg = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wb_q        <= '0;
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the values
      // from before the edge, independent of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wb_q        <= wb_d;
      align_err_q <= align_err_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Reset gates the combinational outputs so upstream sees no stall or redirect.
  assign stall_o         = stall & rst_n;
  assign pc_src_o        = branch_i & zero_i & ~stall_o & rst_n;
  assign branch_target_o = add_result_i;

  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;

  assign reg_write_wb_o  = wb_q.reg_write;
  assign mem_to_reg_wb_o = wb_q.mem_to_reg;
  assign read_data_wb_o  = wb_q.read_data;
  assign alu_result_wb_o = wb_q.alu_result;
  assign write_reg_wb_o  = wb_q.write_reg;
  assign align_err_o     = align_err_q;
  assign bus_err_o       = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random instructions,
// compared against a transaction-level model of the stage's retirement rules.
module tb_mem_stage;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        branch, mem_read, mem_write, reg_write, mem_to_reg, zero;
  logic [31:0] add_result, alu_result, rdata2;
  logic [4:0]  write_reg;
  logic        stall, pc_src;
  logic [31:0] branch_target;
  logic        reg_write_wb, mem_to_reg_wb;
  logic [31:0] read_data_wb, alu_result_wb;
  logic [4:0]  write_reg_wb;
  logic        align_err, bus_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage_if dmem ();

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .branch_i        (branch),
    .mem_read_i      (mem_read),
    .mem_write_i     (mem_write),
    .reg_write_i     (reg_write),
    .mem_to_reg_i    (mem_to_reg),
    .zero_i          (zero),
    .add_result_i    (add_result),
    .alu_result_i    (alu_result),
    .rdata2_i        (rdata2),
    .write_reg_i     (write_reg),
    .dmem            (dmem.master),
    .stall_o         (stall),
    .pc_src_o        (pc_src),
    .branch_target_o (branch_target),
    .reg_write_wb_o  (reg_write_wb),
    .mem_to_reg_wb_o (mem_to_reg_wb),
    .read_data_wb_o  (read_data_wb),
    .alu_result_wb_o (alu_result_wb),
    .write_reg_wb_o  (write_reg_wb),
    .align_err_o     (align_err),
    .bus_err_o       (bus_err)
  );

  typedef struct {
    logic        br, rd, wr, rw, mtr, zero;
    logic [31:0] add, alu, wdata;
    logic [4:0]  wreg;
  } instr_t;

  typedef struct {
    logic        rw, mtr;
    logic [31:0] rd, alu;
    logic [4:0]  wreg;
  } wb_t;

  wb_t wb_exp = '{1'b0, 1'b0, 32'h0, 32'h0, 5'h0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_wb(input string tag, input bit chk_rd);
    check({tag, " reg_write_wb"},  reg_write_wb,  wb_exp.rw);
    check({tag, " mem_to_reg_wb"}, mem_to_reg_wb, wb_exp.mtr);
    check({tag, " alu_result_wb"}, alu_result_wb, wb_exp.alu);
    check({tag, " write_reg_wb"},  write_reg_wb,  wb_exp.wreg);
    if (chk_rd) check({tag, " read_data_wb"}, read_data_wb, wb_exp.rd);
  endtask

  task automatic drive(input instr_t i);
    branch = i.br; mem_read = i.rd; mem_write = i.wr; reg_write = i.rw;
    mem_to_reg = i.mtr; zero = i.zero; add_result = i.add; alu_result = i.alu;
    rdata2 = i.wdata; write_reg = i.wreg;
  endtask

  // Presents one instruction (time = just after a rising edge) and follows it to
  // retirement. ack_k: ACCESS cycle (1-based) in which memory acks; > TIMEOUT = never.
  task automatic run_instr(input string tag, input instr_t ins, input int ack_k);
    logic        memop, mis, exp_stall;
    logic [31:0] rdat;
    int          c, stalls;
    bit          done;
    memop  = ins.rd | ins.wr;
    mis    = memop && (ins.alu[1:0] != 2'b00);
    rdat   = 32'h0;
    c      = 0;
    stalls = 0;
    done   = 1'b0;
    drive(ins);
    dmem.ack   = 1'($urandom_range(0, 1));   // must be ignored in IDLE
    dmem.rdata = $urandom;
    if (!memop || mis) begin
      #1;
      check({tag, " stall"}, stall, 1'b0);
      check({tag, " pc_src"}, pc_src, ins.br & ins.zero);
      check({tag, " branch_target"}, branch_target, ins.add);
      @(posedge clk); #1;
      dmem.ack = 1'b0;
      check({tag, " req idle"}, dmem.req, 1'b0);
      check({tag, " bus_err"}, bus_err, 1'b0);
      check({tag, " align_err"}, align_err, mis);
      wb_exp.rw   = mis ? 1'b0 : ins.rw;
      wb_exp.mtr  = ins.mtr;
      wb_exp.alu  = ins.alu;
      wb_exp.wreg = ins.wreg;
      if (!mis) wb_exp.rd = 32'h0;
      check_wb(tag, !mis);
    end else begin
      while (!done) begin
        if (c > 0) begin
          dmem.ack   = (c == ack_k);
          rdat       = $urandom;
          dmem.rdata = rdat;
        end
        #1;
        exp_stall = (c == 0) || ((c != ack_k) && (c < TIMEOUT));
        if (stall) stalls++;
        check({tag, " stall"}, stall, exp_stall);
        check({tag, " pc_src"}, pc_src, ins.br & ins.zero & ~exp_stall);
        if (c == 0) begin
          check({tag, " req before issue"}, dmem.req, 1'b0);
        end else begin
          check({tag, " req"}, dmem.req, 1'b1);
          check({tag, " we"}, dmem.we, ins.wr);
          check({tag, " addr"}, dmem.addr, ins.alu);
          if (ins.wr) check({tag, " wdata"}, dmem.wdata, ins.wdata);
          check({tag, " bubble reg_write_wb"}, reg_write_wb, 1'b0);
          check({tag, " bubble mem_to_reg_wb"}, mem_to_reg_wb, 1'b0);
          check({tag, " bubble alu_result_wb"}, alu_result_wb, wb_exp.alu);
        end
        done = (c > 0) && ((c == ack_k) || (c == TIMEOUT));
        @(posedge clk); #1;
        dmem.ack = 1'b0;
        c++;
      end
      check({tag, " stall cycles"}, stalls, (ack_k <= TIMEOUT) ? ack_k : TIMEOUT);
      check({tag, " req dropped"}, dmem.req, 1'b0);
      check({tag, " align_err"}, align_err, 1'b0);
      check({tag, " bus_err"}, bus_err, ack_k > TIMEOUT);
      wb_exp.rw   = (ack_k <= TIMEOUT) ? ins.rw : 1'b0;
      wb_exp.mtr  = ins.mtr;
      wb_exp.alu  = ins.alu;
      wb_exp.wreg = ins.wreg;
      if (ack_k <= TIMEOUT) wb_exp.rd = ins.wr ? 32'h0 : rdat;
      check_wb(tag, ack_k <= TIMEOUT);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " req"}, dmem.req, 1'b0);
    check({tag, " we"}, dmem.we, 1'b0);
    check({tag, " addr"}, dmem.addr, 32'h0);
    check({tag, " wdata"}, dmem.wdata, 32'h0);
    check({tag, " wb ctrl"}, {reg_write_wb, mem_to_reg_wb}, 2'b00);
    check({tag, " read_data_wb"}, read_data_wb, 32'h0);
    check({tag, " alu_result_wb"}, alu_result_wb, 32'h0);
    check({tag, " write_reg_wb"}, write_reg_wb, 5'h0);
    check({tag, " errs"}, {align_err, bus_err}, 2'b00);
    check({tag, " stall"}, stall, 1'b0);
    check({tag, " pc_src"}, pc_src, 1'b0);
  endtask

  instr_t nop = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'h0};

  initial begin
    instr_t ins;
    drive(nop);
    branch = 1'b1; zero = 1'b1;
    dmem.ack = 1'b0; dmem.rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    #3 rst_n = 1'b1;
    drive(nop);
    @(posedge clk); #1;

    // R-type passes through in one edge.
    ins = nop; ins.rw = 1'b1; ins.alu = 32'h0000_002A; ins.wreg = 5'd9;
    run_instr("rtype", ins, 0);

    // Load acked in the third ACCESS cycle.
    ins = nop; ins.rd = 1'b1; ins.rw = 1'b1; ins.mtr = 1'b1; ins.alu = 32'h100; ins.wreg = 5'd3;
    run_instr("load", ins, 3);
    check("load rdata", read_data_wb, wb_exp.rd);

    // Store acked in the first ACCESS cycle.
    ins = nop; ins.wr = 1'b1; ins.alu = 32'h104; ins.wdata = 32'h1234_5678;
    run_instr("store", ins, 1);
    check("store read_data_wb", read_data_wb, 32'h0);

    // Misaligned load: no request, align_err pulse.
    ins = nop; ins.rd = 1'b1; ins.rw = 1'b1; ins.mtr = 1'b1; ins.alu = 32'h102; ins.wreg = 5'd4;
    run_instr("misaligned", ins, 0);

    // Load never acked: timeout.
    ins = nop; ins.rd = 1'b1; ins.rw = 1'b1; ins.mtr = 1'b1; ins.alu = 32'h200; ins.wreg = 5'd5;
    run_instr("timeout", ins, TIMEOUT + 5);

    // Ack in the same cycle the timeout would fire: ack wins.
    ins = nop; ins.rd = 1'b1; ins.rw = 1'b1; ins.alu = 32'h300; ins.wreg = 5'd6;
    run_instr("ack_at_limit", ins, TIMEOUT);

    // Taken branch.
    ins = nop; ins.br = 1'b1; ins.zero = 1'b1; ins.add = 32'h40;
    run_instr("branch", ins, 0);
    check("branch bus_err cleared", bus_err, 1'b0);

    // Random instruction mix.
    for (int n = 0; n < 60; n++) begin
      ins.br    = 1'($urandom_range(0, 1));
      ins.zero  = 1'($urandom_range(0, 1));
      ins.rd    = 1'($urandom_range(0, 1));
      ins.wr    = 1'($urandom_range(0, 1));
      ins.rw    = 1'($urandom_range(0, 1));
      ins.mtr   = 1'($urandom_range(0, 1));
      ins.add   = $urandom;
      ins.alu   = $urandom;
      if ($urandom_range(0, 3) != 0) ins.alu[1:0] = 2'b00;
      ins.wdata = $urandom;
      ins.wreg  = 5'($urandom);
      run_instr("random", ins, int'($urandom_range(1, TIMEOUT + 2)));
    end

    // Reset in the middle of an access.
    ins = nop; ins.rd = 1'b1; ins.rw = 1'b1; ins.alu = 32'h400; ins.br = 1'b1; ins.zero = 1'b1;
    drive(ins);
    @(posedge clk); #1;
    check("mid-reset req before", dmem.req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid-reset");
    @(posedge clk); #1;
    check("mid-reset req held", dmem.req, 1'b0);
    drive(nop);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset req", dmem.req, 1'b0);
    check("post-reset errs", {align_err, bus_err}, 2'b00);
    wb_exp = '{1'b0, 1'b0, 32'h0, 32'h0, 5'h0};
    check_wb("post-reset", 1'b1);
    ins = nop; ins.rd = 1'b1; ins.rw = 1'b1; ins.alu = 32'h500; ins.wreg = 5'd7;
    run_instr("post-reset load", ins, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage placed directly downstream of the EX/MEM pipeline register. It resolves branches, runs loads and stores against a variable-latency data-memory port with a request/acknowledge handshake and a timeout, and stalls upstream while an access is outstanding. It also holds the MEM/WB pipeline register that feeds write-back.

## Interface
- TIMEOUT, 15: maximum number of ACCESS cycles without `dmem_ack` before the access is abandoned; legal range 2..255.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- Branch, MemRead, MemWrite, RegWrite, MemtoReg  in  1 each  control bits from EX/MEM
- zero  in  1  ALU zero flag from EX/MEM
- add_result  in  32  branch target from EX/MEM
- alu_result  in  32  ALU result; this is the memory address for loads and stores
- rdata2  in  32  store data
- write_reg  in  5  destination register
- dmem_req  out  1  registered; high while an access is outstanding
- dmem_we  out  1  registered; 1 = write
- dmem_addr  out  32  registered address
- dmem_wdata  out  32  registered write data
- dmem_ack  in  1  access complete; `dmem_rdata` is valid in the same cycle
- dmem_rdata  in  32  read data
- stall  out  1  combinational; upstream holds EX/MEM while this is high
- PCSrc  out  1  combinational; high when the branch is taken
- branch_target  out  32  combinational; equals `add_result`
- RegWrite_wb, MemtoReg_wb  out  1 each  MEM/WB control
- read_data_wb, alu_result_wb  out  32 each  MEM/WB data
- write_reg_wb  out  5  MEM/WB destination register
- align_err, bus_err  out  1 each  registered single-cycle error pulses

## Operation
- memop = MemRead | MemWrite. If both bits are set, the access is treated as a write.
- Misaligned access: memop with `alu_result[1:0] != 0`.
- PCSrc = Branch & zero & ~stall.
- FSM states are IDLE and ACCESS.
- **IDLE, aligned memop:**
  - `stall` = 1.
  - Next edge: go to ACCESS; `dmem_req` = 1; `dmem_we` = MemWrite; `dmem_addr` = alu_result; `dmem_wdata` = rdata2; counter = 0.
  - MEM/WB receives a bubble.
- **IDLE, misaligned memop:**
  - `stall` = 0; no request is issued.
  - Next edge: `align_err` = 1 for one cycle; MEM/WB loads with `RegWrite_wb` forced to 0.
- **IDLE, no memop:**
  - `stall` = 0.
  - Next edge: MEM/WB loads RegWrite, MemtoReg, alu_result and write_reg; `read_data_wb` = 0.
- **ACCESS, `dmem_ack` = 1:**
  - `stall` = 0.
  - Next edge: MEM/WB loads the instruction; `read_data_wb` = dmem_rdata for a read, 0 for a write; `dmem_req` = 0; go to IDLE.
- **ACCESS, no ack, counter < TIMEOUT-1:**
  - `stall` = 1; counter increments.
  - MEM/WB receives a bubble.
- **ACCESS, no ack, counter = TIMEOUT-1:**
  - `stall` = 0.
  - Next edge: `dmem_req` = 0; `bus_err` = 1 for one cycle; MEM/WB loads with `RegWrite_wb` forced to 0; go to IDLE.
- If ack and timeout coincide, ack wins.
- Bubble: `RegWrite_wb` = 0 and `MemtoReg_wb` = 0; the MEM/WB data fields keep their previous values.
- `dmem_addr`, `dmem_wdata` and `dmem_we` stay stable for as long as `dmem_req` is high.
- `dmem_ack` is ignored in IDLE.
- The counter is 8 bits and never wraps: it stops at TIMEOUT-1.

## Timing
- Reset (rst = 0, asynchronous): state = IDLE; counter = 0.
- During reset, every registered output is 0: `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, all five MEM/WB outputs, `align_err` and `bus_err`.
- While rst = 0, `stall` and `PCSrc` are forced to 0.
- Reset asserted mid-access drops `dmem_req` immediately. No error pulse is produced.
- Non-memory instruction: MEM/WB is valid 1 edge after the instruction is presented; no stall.
- Load or store with ack in ACCESS cycle k (k ≥ 1): `stall` is high for k cycles; MEM/WB is valid k+1 edges after the instruction is presented.
- The minimum load latency is 2 edges, with 1 stall cycle.
- Timeout: `stall` is high for TIMEOUT cycles; `bus_err` rises at edge TIMEOUT+1.
- Back-to-back memops: a new request issues no earlier than 1 cycle after `dmem_req` falls, because the next op spends one cycle in IDLE.

## Test plan
- Reset, then hold rst = 0 mid-ACCESS -> `dmem_req` falls asynchronously; all outputs read 0; after release, state is IDLE with no error pulses.
- R-type: RegWrite = 1, alu_result = 0x0000_002A, write_reg = 9 -> next edge `RegWrite_wb` = 1, `alu_result_wb` = 0x2A, `write_reg_wb` = 9, `stall` never high.
- Load: alu_result = 0x100, ack 3 cycles after `dmem_req` rises with rdata = 0xDEAD_BEEF -> `stall` high 3 cycles, `dmem_addr` = 0x100, `read_data_wb` = 0xDEADBEEF, `MemtoReg_wb` = 1.
- Store: alu_result = 0x104, rdata2 = 0x1234_5678, ack in the first ACCESS cycle -> `dmem_we` = 1, `dmem_wdata` = 0x12345678, 1 stall cycle, `read_data_wb` = 0.
- Misaligned load: address 0x102 -> no `dmem_req`, `align_err` pulses 1 cycle, `RegWrite_wb` = 0, `stall` = 0.
- TIMEOUT = 4, load never acked -> `stall` high 4 cycles, `bus_err` pulses, `RegWrite_wb` = 0; then Branch = 1, zero = 1, add_result = 0x40 -> `PCSrc` = 1, `branch_target` = 0x40.
